// File: rtl/char_term_ctrl.sv
// Text-terminal controller: cursor, newline, backspace, scroll and clear
// sequencing for a COLS x ROWS character RAM. Optional macro: CHAR_TERM_CURSOR_BLINK_EN.
//
// Ports:
//   pclk, reset           clock, synchronous active-high reset
//   in_valid/in_char      ASCII input, accepted when in_ready
//   in_ready              high in IDLE while no clear is requested
//   clr_req               level request for full-screen clear
//   vsync                 frame strobe for cursor blink (blink build only)
//   wr_en/row/col/data    registered character RAM write port
//   cur_col/cur_row       cursor position (logical row, 0 = screen top)
//   top_row               physical row shown at screen top
//   busy                  controller is running a multi-cycle fill
//   cursor_on             cursor visible
module char_term_ctrl #(
  parameter int unsigned COLS         = 70,
  parameter int unsigned ROWS         = 30,
  parameter logic [7:0]  BLANK        = 8'h20,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  input  logic       clr_req,
  input  logic       vsync,
  output logic       wr_en,
  output logic [4:0] wr_row,
  output logic [6:0] wr_col,
  output logic [7:0] wr_data,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row,
  output logic [4:0] top_row,
  output logic       busy,
  output logic       cursor_on
);

  localparam logic [6:0] COLS_V   = 7'(COLS);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] ROWS_V   = 5'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cur_col_q, cur_col_d;
  logic [4:0] cur_row_q, cur_row_d;
  logic [4:0] top_row_q, top_row_d;
  logic [4:0] fill_row_q, fill_row_d;
  logic [6:0] fill_col_q, fill_col_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_row_q, wr_row_d;
  logic [6:0] wr_col_q, wr_col_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       do_nl;
  logic       accept;
  logic       is_print, is_nl, is_bs;

  // Logical row to physical row; operands are both < ROWS.
  function automatic logic [4:0] phys(input logic [4:0] r,
                                      input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (s >= {1'b0, ROWS_V}) s = s - {1'b0, ROWS_V};
    return s[4:0];
  endfunction

  assign in_ready = (state_q == IDLE) & ~clr_req;
  assign accept   = in_valid & in_ready;
  assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign is_nl    = (in_char == 8'h0A) || (in_char == 8'h0D);
  assign is_bs    = (in_char == 8'h08);

  always_comb begin
    state_d    = state_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    top_row_d  = top_row_q;
    fill_row_d = fill_row_q;
    fill_col_d = fill_col_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    do_nl      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLR_ALL;
          fill_row_d = '0;
          fill_col_d = '0;
        end else if (in_valid) begin
          unique case (1'b1)
            is_print: begin
              wr_en_d   = 1'b1;
              wr_row_d  = phys(cur_row_q, top_row_q);
              wr_col_d  = cur_col_q;
              wr_data_d = in_char;
              if (cur_col_q == LAST_COL) do_nl = 1'b1;
              else cur_col_d = cur_col_q + 7'd1;
            end
            is_nl: do_nl = 1'b1;
            is_bs: begin
              if (cur_col_q != 7'd0) begin
                cur_col_d = cur_col_q - 7'd1;
                wr_en_d   = 1'b1;
                wr_row_d  = phys(cur_row_q, top_row_q);
                wr_col_d  = cur_col_q - 7'd1;
                wr_data_d = BLANK;
              end else if (cur_row_q != 5'd0) begin
                cur_row_d = cur_row_q - 5'd1;
                cur_col_d = LAST_COL;
                wr_en_d   = 1'b1;
                wr_row_d  = phys(cur_row_q - 5'd1, top_row_q);
                wr_col_d  = LAST_COL;
                wr_data_d = BLANK;
              end
            end
            default: ;
          endcase
          if (do_nl) begin
            cur_col_d = '0;
            if (cur_row_q != LAST_ROW) begin
              cur_row_d = cur_row_q + 5'd1;
            end else begin
              top_row_d = (top_row_q == LAST_ROW) ? 5'd0
                                                  : top_row_q + 5'd1;
              state_d    = CLR_LINE;
              // New bottom line lands on the old top physical row.
              fill_row_d = top_row_q;
              if (is_print) begin
                // Char write owns the next cycle; fill starts after.
                fill_col_d = '0;
              end else begin
                wr_en_d    = 1'b1;
                wr_row_d   = top_row_q;
                wr_col_d   = '0;
                wr_data_d  = BLANK;
                fill_col_d = 7'd1;
              end
            end
          end
        end
      end
      CLR_LINE: begin
        if (fill_col_q == COLS_V) begin
          state_d = IDLE;
        end else begin
          wr_en_d    = 1'b1;
          wr_row_d   = fill_row_q;
          wr_col_d   = fill_col_q;
          wr_data_d  = BLANK;
          fill_col_d = fill_col_q + 7'd1;
        end
      end
      CLR_ALL: begin
        if (fill_row_q == ROWS_V) begin
          state_d   = IDLE;
          cur_col_d = '0;
          cur_row_d = '0;
          top_row_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_row_d  = fill_row_q;
          wr_col_d  = fill_col_q;
          wr_data_d = BLANK;
          if (fill_col_q == LAST_COL) begin
            fill_col_d = '0;
            fill_row_d = fill_row_q + 5'd1;
          end else begin
            fill_col_d = fill_col_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      top_row_q  <= '0;
      fill_row_q <= '0;
      fill_col_q <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      top_row_q  <= top_row_d;
      fill_row_q <= fill_row_d;
      fill_col_q <= fill_col_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_row  = wr_row_q;
  assign wr_col  = wr_col_q;
  assign wr_data = wr_data_q;
  assign cur_col = cur_col_q;
  assign cur_row = cur_row_q;
  assign top_row = top_row_q;
  assign busy    = (state_q != IDLE);

`ifdef CHAR_TERM_CURSOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] LAST_FRAME = BW'(BLINK_FRAMES - 1);

  logic          vsync_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          cursor_on_q, cursor_on_d;
  logic          vs_rise;

  assign vs_rise = vsync & ~vsync_q;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    cursor_on_d = cursor_on_q;
    if (accept) begin
      blink_cnt_d = '0;
      cursor_on_d = 1'b1;
    end else if (vs_rise) begin
      if (blink_cnt_q == LAST_FRAME) begin
        blink_cnt_d = '0;
        cursor_on_d = ~cursor_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      blink_cnt_q <= '0;
      cursor_on_q <= 1'b1;
    end else begin
      vsync_q     <= vsync;
      blink_cnt_q <= blink_cnt_d;
      cursor_on_q <= cursor_on_d;
    end
  end

  assign cursor_on = cursor_on_q;
`else
  logic [31:0] unused_cfg;
  logic        unused_acc;
  assign unused_cfg = 32'(BLINK_FRAMES) ^ {31'd0, vsync};
  assign unused_acc = accept;
  assign cursor_on  = 1'b1;
`endif

endmodule
